// File: rtl/wb_regfile.sv
// Writeback stage and 16-entry architectural register file with print, jump redirect, halt and retire counting.
// Optional write-to-read forwarding is enabled by defining WB_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              x2_valid,
    input  logic [15:0]       x2_ins,
    input  logic [15:0]       x2_pc,
    input  logic [DATA_W-1:0] x2_result,
    input  logic [3:0]        fr_ra,
    input  logic [3:0]        fr_rb,
    output logic [DATA_W-1:0] fr_val_a,
    output logic [DATA_W-1:0] fr_val_b,
    output logic              wb_redirect,
    output logic [15:0]       wb_target,
    output logic              print_valid,
    output logic [7:0]        print_data,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] regs [NREGS];

    logic [3:0]  opcode, subcode, rt;
    logic [15:0] pc_plus2;
    logic        is_write, is_jump, is_halt;
    logic        accept, do_write, do_print, do_redirect;

    assign opcode   = x2_ins[15:12];
    assign subcode  = x2_ins[7:4];
    assign rt       = x2_ins[3:0];
    assign pc_plus2 = x2_pc + 16'd2;

    always_comb begin
        is_write = 1'b0;
        is_jump  = 1'b0;
        is_halt  = 1'b0;
        case (opcode)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd14: is_write = 1'b1;
            4'd4, 4'd12, 4'd13:                              is_write = (subcode != 4'd1);
            4'd6:                                            is_jump  = 1'b1;
            default:                                         is_halt  = 1'b1;
        endcase
    end

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        do_write    = 1'b0;
        do_print    = 1'b0;
        do_redirect = 1'b0;
        if (state == RUN && x2_valid) begin
            accept      = 1'b1;
            do_write    = is_write && (rt != 4'd0);
            do_print    = is_write && (rt == 4'd0);
            do_redirect = is_jump && (x2_result[15:0] != pc_plus2);
            if (is_halt)
                state_nx = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
            wb_redirect <= 1'b0;
            wb_target   <= '0;
            print_valid <= 1'b0;
            print_data  <= '0;
            retired     <= '0;
        end else begin
            wb_redirect <= do_redirect;
            print_valid <= do_print;
            if (do_write)
                regs[rt] <= x2_result;
            if (do_print)
                print_data <= x2_result[7:0];
            if (do_redirect)
                wb_target <= x2_result[15:0];
            if (accept)
                retired <= retired + 1'b1;
        end
    end

    assign halted = (state == HALTED);

    always_comb begin
        fr_val_a = regs[fr_ra];
        fr_val_b = regs[fr_rb];
`ifdef WB_BYPASS_EN
        // Forward the retiring result so the read stage needs no hazard stall.
        if (do_write && fr_ra == rt)
            fr_val_a = x2_result;
        if (do_write && fr_rb == rt)
            fr_val_b = x2_result;
`endif
        if (fr_ra == 4'd0)
            fr_val_a = '0;
        if (fr_rb == 4'd0)
            fr_val_b = '0;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile with hand-computed expectations.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        x2_valid;
    logic [15:0] x2_ins, x2_pc, x2_result;
    logic [3:0]  fr_ra, fr_rb;
    logic [15:0] fr_val_a, fr_val_b;
    logic        wb_redirect;
    logic [15:0] wb_target;
    logic        print_valid;
    logic [7:0]  print_data;
    logic        halted;
    logic [31:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    wb_regfile #(.DATA_W(16), .NREGS(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .x2_valid(x2_valid), .x2_ins(x2_ins), .x2_pc(x2_pc), .x2_result(x2_result),
        .fr_ra(fr_ra), .fr_rb(fr_rb), .fr_val_a(fr_val_a), .fr_val_b(fr_val_b),
        .wb_redirect(wb_redirect), .wb_target(wb_target),
        .print_valid(print_valid), .print_data(print_data),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [15:0] ins, input logic [15:0] pc, input logic [15:0] res);
        x2_valid  = 1'b1;
        x2_ins    = ins;
        x2_pc     = pc;
        x2_result = res;
        @(posedge clk); #1;
        x2_valid  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; x2_valid = 1'b0; x2_ins = '0; x2_pc = '0; x2_result = '0;
        fr_ra = 4'd3; fr_rb = 4'd0;
        #22;
        check("rst_val_a", 32'(fr_val_a), 32'h0);
        check("rst_val_b", 32'(fr_val_b), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_retired", retired, 32'h0);
        check("rst_print_valid", 32'(print_valid), 32'h0);
        check("rst_redirect", 32'(wb_redirect), 32'h0);
        check("rst_target", 32'(wb_target), 32'h0);
        rst_n = 1'b1;
        idle();

        // add r5
        fr_ra = 4'd5; fr_rb = 4'd5;
        retire(16'h0125, 16'h0000, 16'h1234);
        check("add_val_a", 32'(fr_val_a), 32'h1234);
        check("add_val_b_same", 32'(fr_val_b), 32'h1234);
        check("add_retired", retired, 32'd1);
        check("add_no_print", 32'(print_valid), 32'h0);

        // print via r0
        fr_ra = 4'd0;
        retire(16'h0040, 16'h0002, 16'h0148);
        check("print_valid", 32'(print_valid), 32'h1);
        check("print_data", 32'(print_data), 32'h48);
        check("r0_reads_zero", 32'(fr_val_a), 32'h0);
        check("print_retired", retired, 32'd2);
        idle();
        check("print_pulse_clear", 32'(print_valid), 32'h0);
        check("print_data_hold", 32'(print_data), 32'h48);

        // taken jump
        retire(16'h6001, 16'h0010, 16'h0040);
        check("jmp_redirect", 32'(wb_redirect), 32'h1);
        check("jmp_target", 32'(wb_target), 32'h0040);
        check("jmp_retired", retired, 32'd3);
        idle();
        check("jmp_pulse_clear", 32'(wb_redirect), 32'h0);
        check("jmp_target_hold", 32'(wb_target), 32'h0040);

        // not-taken jump, and wrap boundary 0xFFFE + 2 = 0
        retire(16'h6001, 16'h0010, 16'h0012);
        check("jmp_nt_redirect", 32'(wb_redirect), 32'h0);
        check("jmp_nt_target", 32'(wb_target), 32'h0040);
        retire(16'h6002, 16'hFFFE, 16'h0000);
        check("jmp_wrap_redirect", 32'(wb_redirect), 32'h0);
        check("jmp_wrap_retired", retired, 32'd5);

        // same-cycle write/read of r7
        retire(16'h0017, 16'h0020, 16'h0001);
        x2_valid = 1'b1; x2_ins = 16'h1007; x2_pc = 16'h0022; x2_result = 16'hBEEF;
        fr_ra = 4'd7;
        #1;
`ifdef WB_BYPASS_EN
        check("bypass_val_a", 32'(fr_val_a), 32'hBEEF);
`else
        check("bypass_val_a", 32'(fr_val_a), 32'h0001);
`endif
        @(posedge clk); #1;
        x2_valid = 1'b0;
        check("after_write_r7", 32'(fr_val_a), 32'hBEEF);
        check("bypass_retired", retired, 32'd7);

        // store (op 4 sub 1) does not write; op 4 sub 0 does
        fr_ra = 4'd3;
        retire(16'h4013, 16'h0024, 16'h5555);
        check("store_no_write", 32'(fr_val_a), 32'h0);
        retire(16'h4003, 16'h0026, 16'h3333);
        check("op4_write", 32'(fr_val_a), 32'h3333);
        check("op4_retired", retired, 32'd9);

        // halt
        retire(16'hF000, 16'h0028, 16'h0000);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_retired", retired, 32'd10);
        retire(16'h0123, 16'h002A, 16'h9999);
        check("halted_no_write", 32'(fr_val_a), 32'h3333);
        check("halted_retired_frozen", retired, 32'd10);
        retire(16'h0040, 16'h002C, 16'h0077);
        check("halted_no_print", 32'(print_valid), 32'h0);
        retire(16'h6001, 16'h002E, 16'h0100);
        check("halted_no_redirect", 32'(wb_redirect), 32'h0);
        check("halted_sticky", 32'(halted), 32'h1);

        rst_n = 1'b0; #2;
        check("rst2_halted", 32'(halted), 32'h0);
        check("rst2_retired", retired, 32'h0);
        check("rst2_reg3", 32'(fr_val_a), 32'h0);
        #5; rst_n = 1'b1;
        idle();

        // in-flight pulse dropped by reset
        retire(16'h0040, 16'h0000, 16'h00AB);
        check("pre_rst_print", 32'(print_valid), 32'h1);
        rst_n = 1'b0; #1;
        check("rst_drops_pulse", 32'(print_valid), 32'h0);
        check("rst_clears_pdata", 32'(print_data), 32'h0);
        #3; rst_n = 1'b1;
        idle();

        // unused opcode 5 halts
        retire(16'h5000, 16'h0000, 16'h0000);
        check("op5_halt", 32'(halted), 32'h1);
        check("op5_retired", retired, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
